// File: rtl/line_step_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// line_step_pkg
// Shared definitions for the line step scheduler:
//   line_step_state_e  - scheduler FSM state encoding (also exported for debug)
//   DIR_SETUP_CYCLES   - cycles the direction outputs settle before a first pulse
//   abs_mag()          - magnitude of a wide signed value. Callers sign-extend
//                        into MAG_W bits and truncate the result, so the most
//                        negative coordinate maps to its true magnitude.
// -----------------------------------------------------------------------------
package line_step_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_DIR_HOLD = 3'd2,
        ST_PULSE    = 3'd3,
        ST_GAP      = 3'd4,
        ST_FINISH   = 3'd5
    } line_step_state_e;

    localparam int DIR_SETUP_CYCLES = 1;
    localparam int MAG_W            = 64;

    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] v);
        return v[MAG_W-1] ? MAG_W'(-v) : MAG_W'(v);
    endfunction

endpackage

// File: rtl/line_step_scheduler_step_pulse_timer.sv
// -----------------------------------------------------------------------------
// step_pulse_timer
// Times one step event: counts cycles from the event's rising edge.
//   clock, reset     - clock, synchronous active-low reset
//   start_i          - begin a new event (count restarts at 0 next cycle)
//   clear_i          - stop the timer
//   period_i         - cycles between event rising edges (>= 2*PULSE_CYCLES)
//   pulse_active_o   - current cycle lies inside the step pulse
//   pulse_end_o      - current cycle is the last pulse-high cycle
//   period_done_o    - current cycle is the last cycle of the period
// -----------------------------------------------------------------------------
module step_pulse_timer #(
    parameter int PERIOD_W     = 32,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_i,
    input  logic                clear_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                pulse_active_o,
    output logic                pulse_end_o,
    output logic                period_done_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                run_q, run_d;

    always_comb begin
        pulse_active_o = run_q && (cnt_q < PERIOD_W'(PULSE_CYCLES));
        pulse_end_o    = run_q && (cnt_q == PERIOD_W'(PULSE_CYCLES - 1));
        period_done_o  = run_q && (cnt_q == (period_i - PERIOD_W'(1)));

        cnt_d = cnt_q;
        run_d = run_q;
        // start wins over period_done so back-to-back events chain seamlessly
        if (start_i) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (clear_i || period_done_o) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/line_step_scheduler.sv
// -----------------------------------------------------------------------------
// line_step_scheduler
// Two-axis stepper controller: takes one relative line move at a time and
// interpolates it with Bresenham error accumulation into step/dir outputs.
//
// Handshake: a command transfers on a rising clock edge where cmd_valid and
// cmd_ready are both 1; cmd_* are captured then and may change afterwards.
// cmd_ready is 1 only in IDLE.
//
// Ports:
//   clock, reset           - clock, synchronous active-low reset
//   cmd_valid/cmd_ready    - command handshake
//   cmd_dx, cmd_dy         - signed displacement in steps
//   cmd_period             - cycles between step events (clamped to 2*PULSE_CYCLES)
//   abort                  - end the move at the next safe point
//   step_x, step_y         - step pulses, PULSE_CYCLES high
//   dir_x, dir_y           - direction levels, 1 = positive
//   busy                   - move in progress (SETUP..FINISH)
//   done                   - one-cycle pulse at move end or abort
//   dbg_state_o            - current FSM state
// Optional (macro LINE_STEP_POS_TRACK_EN):
//   pos_x, pos_y           - signed 32-bit position counters
//   pos_clear              - zero both positions (wins over a coincident step)
// -----------------------------------------------------------------------------
module line_step_scheduler
    import line_step_pkg::*;
#(
    parameter int COORD_W      = 16,
    parameter int PERIOD_W     = 32,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [COORD_W-1:0] cmd_dx,
    input  logic signed [COORD_W-1:0] cmd_dy,
    input  logic [PERIOD_W-1:0]       cmd_period,
    input  logic                      abort,
    output logic                      step_x,
    output logic                      step_y,
    output logic                      dir_x,
    output logic                      dir_y,
    output logic                      busy,
    output logic                      done,
`ifdef LINE_STEP_POS_TRACK_EN
    output logic signed [31:0]        pos_x,
    output logic signed [31:0]        pos_y,
    input  logic                      pos_clear,
`endif
    output line_step_state_e          dbg_state_o
);

    localparam int                  ERR_W      = COORD_W + 2;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CYCLES);

    line_step_state_e          state_q, state_d;
    logic signed [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [PERIOD_W-1:0]       period_q, period_d;
    logic [COORD_W-1:0]        n_q, n_d, minor_q, minor_d, remaining_q, remaining_d;
    logic                      x_major_q, x_major_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic [3:0]                hold_q, hold_d;
    logic                      abort_q, abort_d;
    logic                      sel_x_q, sel_x_d, sel_y_q, sel_y_d;
    logic                      dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic                      ready_q, ready_d, busy_q, busy_d, done_q, done_d;

    logic [COORD_W-1:0]        ax, ay, n_setup, minor_setup;
    logic signed [ERR_W-1:0]   err_m, err_evt;
    logic                      minor_hit, do_event, abort_now;
    logic                      pulse_active, pulse_end, period_done;

    step_pulse_timer #(
        .PERIOD_W    (PERIOD_W),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .start_i       (do_event),
        .clear_i       (state_q == ST_FINISH),
        .period_i      (period_q),
        .pulse_active_o(pulse_active),
        .pulse_end_o   (pulse_end),
        .period_done_o (period_done)
    );

    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        period_d    = period_q;
        n_d         = n_q;
        minor_d     = minor_q;
        remaining_d = remaining_q;
        x_major_d   = x_major_q;
        err_d       = err_q;
        hold_d      = hold_q;
        abort_d     = abort_q;
        sel_x_d     = sel_x_q;
        sel_y_d     = sel_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        do_event    = 1'b0;

        ax          = COORD_W'(abs_mag(MAG_W'(dx_q)));
        ay          = COORD_W'(abs_mag(MAG_W'(dy_q)));
        n_setup     = (ax >= ay) ? ax : ay;
        minor_setup = (ax >= ay) ? ay : ax;

        // Bresenham step: minor axis moves whenever the error goes negative
        err_m       = err_q - $signed({2'b00, minor_q});
        minor_hit   = err_m[ERR_W-1];
        err_evt     = minor_hit ? (err_m + $signed({2'b00, n_q})) : err_m;

        // abort is sticky once seen so a running pulse can finish first
        abort_now   = abort_q | abort;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (cmd_valid && ready_q) begin
                    dx_d     = cmd_dx;
                    dy_d     = cmd_dy;
                    period_d = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
                    // abort seen with the accept takes effect from SETUP
                    abort_d  = abort;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                abort_d     = abort_now;
                dir_x_d     = ~dx_q[COORD_W-1];
                dir_y_d     = ~dy_q[COORD_W-1];
                n_d         = n_setup;
                minor_d     = minor_setup;
                x_major_d   = (ax >= ay);
                err_d       = $signed({3'b000, n_setup[COORD_W-1:1]});
                remaining_d = n_setup;
                hold_d      = '0;
                state_d     = (abort_now || n_setup == '0) ? ST_FINISH : ST_DIR_HOLD;
            end
            ST_DIR_HOLD: begin
                abort_d = abort_now;
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else if (hold_q == 4'(DIR_SETUP_CYCLES - 1)) begin
                    do_event = 1'b1;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_PULSE: begin
                abort_d = abort_now;
                if (pulse_end) begin
                    state_d = abort_now ? ST_FINISH : ST_GAP;
                end
            end
            ST_GAP: begin
                abort_d = abort_now;
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else if (period_done) begin
                    if (remaining_q != '0) begin
                        do_event = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_event) begin
            state_d     = ST_PULSE;
            err_d       = err_evt;
            remaining_d = remaining_q - COORD_W'(1);
            sel_x_d     = x_major_q | minor_hit;
            sel_y_d     = ~x_major_q | minor_hit;
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dx_q        <= '0;
            dy_q        <= '0;
            period_q    <= '0;
            n_q         <= '0;
            minor_q     <= '0;
            remaining_q <= '0;
            x_major_q   <= 1'b0;
            err_q       <= '0;
            hold_q      <= '0;
            abort_q     <= 1'b0;
            sel_x_q     <= 1'b0;
            sel_y_q     <= 1'b0;
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            period_q    <= period_d;
            n_q         <= n_d;
            minor_q     <= minor_d;
            remaining_q <= remaining_d;
            x_major_q   <= x_major_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            abort_q     <= abort_d;
            sel_x_q     <= sel_x_d;
            sel_y_q     <= sel_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef LINE_STEP_POS_TRACK_EN
    logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;

    // positions move on the same edge the step outputs rise
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (do_event && sel_x_d) pos_x_d = dir_x_q ? (pos_x_q + 32'sd1) : (pos_x_q - 32'sd1);
        if (do_event && sel_y_d) pos_y_d = dir_y_q ? (pos_y_q + 32'sd1) : (pos_y_q - 32'sd1);
        if (pos_clear) begin
            pos_x_d = '0;
            pos_y_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;
`endif

    // the timer bounds the pulse width, so a move cut short never truncates it
    assign step_x      = sel_x_q & pulse_active;
    assign step_y      = sel_y_q & pulse_active;
    assign dir_x       = dir_x_q;
    assign dir_y       = dir_y_q;
    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_line_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_line_step_scheduler
// Directed and randomized moves against a timing/Bresenham model written from
// the move rules: event i rises 2+i*eff cycles after the accept edge, the minor
// axis steps on event k when ceil((k*minor - n/2)/n) increases, and an abort
// ends the move after the pulse in flight (or at once outside a pulse).
// Build with LINE_STEP_POS_TRACK_EN defined to also exercise position tracking.
// -----------------------------------------------------------------------------
module tb_line_step_scheduler;
    import line_step_pkg::*;

    localparam int COORD_W  = 16;
    localparam int PERIOD_W = 32;
    localparam int P        = 4;
    localparam int NO_ABORT = -1000;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic                      cmd_valid = 1'b0;
    logic                      cmd_ready;
    logic signed [COORD_W-1:0] cmd_dx = '0;
    logic signed [COORD_W-1:0] cmd_dy = '0;
    logic [PERIOD_W-1:0]       cmd_period = '0;
    logic                      abort = 1'b0;
    logic                      step_x, step_y, dir_x, dir_y, busy, done;
    line_step_state_e          dbg_state;
`ifdef LINE_STEP_POS_TRACK_EN
    logic signed [31:0]        pos_x, pos_y;
    logic                      pos_clear = 1'b0;
    int                        exp_pos_x = 0;
    int                        exp_pos_y = 0;
`endif
    int                        clear_j = NO_ABORT;

    line_step_scheduler #(
        .COORD_W(COORD_W), .PERIOD_W(PERIOD_W), .PULSE_CYCLES(P)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_period(cmd_period),
        .abort(abort),
        .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
        .busy(busy), .done(done),
`ifdef LINE_STEP_POS_TRACK_EN
        .pos_x(pos_x), .pos_y(pos_y), .pos_clear(pos_clear),
`endif
        .dbg_state_o(dbg_state)
    );

    // scoreboard: {step_x, step_y, done, busy, cmd_ready} per cycle
    logic [4:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int minor_count(input int k, input int mn, input int n);
        int a;
        a = k * mn - n / 2;
        return (a <= 0) ? 0 : (a + n - 1) / n;
    endfunction

    // drive one move; ja = cycle index (after accept edge) in which abort is
    // held high, -1 = with the accept, NO_ABORT = none
    task automatic run_move(input string name, input int dx, input int dy,
                            input int period, input int ja);
        int ax, ay, n, mn, eff, fin, nev, s, ev, ph, wait_cyc;
        logic xmaj, hit, sx, sy;
        ax   = (dx < 0) ? -dx : dx;
        ay   = (dy < 0) ? -dy : dy;
        n    = (ax >= ay) ? ax : ay;
        mn   = (ax >= ay) ? ay : ax;
        xmaj = (ax >= ay);
        eff  = (period < 2 * P) ? 2 * P : period;
        fin  = (n == 0) ? 1 : 2 + n * eff;
        if (ja != NO_ABORT && ja < fin) begin
            if (ja < 1) begin
                fin = 1;
            end else begin
                fin = ja + 1;
                for (int i = 0; i < n; i++) begin
                    s = 2 + i * eff;
                    if (ja >= s && ja < s + P) fin = s + P;
                end
            end
        end
        nev = 0;
        for (int i = 0; i < n; i++) if (2 + i * eff < fin) nev++;

        exp_q.delete();
        for (int j = 0; j <= fin + 1; j++) begin
            sx = 1'b0;
            sy = 1'b0;
            if (j >= 2) begin
                ev = (j - 2) / eff;
                ph = (j - 2) % eff;
                if (ev < nev && ph < P) begin
                    hit = minor_count(ev + 1, mn, n) > minor_count(ev, mn, n);
                    sx  = xmaj | hit;
                    sy  = ~xmaj | hit;
                end
            end
            exp_q.push_back({sx, sy, (j == fin), (j <= fin), (j > fin)});
        end

        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 20) begin
            @(posedge clock); #1;
            wait_cyc++;
        end
        check({name, "_ready_wait"}, 32'(cmd_ready), 32'd1);

        cmd_valid  = 1'b1;
        cmd_dx     = COORD_W'(dx);
        cmd_dy     = COORD_W'(dy);
        cmd_period = PERIOD_W'(period);
        abort      = (ja == -1);
        @(posedge clock); #1;
        cmd_valid  = 1'b0;
        cmd_dx     = COORD_W'($urandom);
        cmd_dy     = COORD_W'($urandom);
        cmd_period = PERIOD_W'($urandom_range(0, 50));

        for (int j = 0; j <= fin + 1; j++) begin
            logic [4:0] e;
            e = exp_q.pop_front();
`ifdef LINE_STEP_POS_TRACK_EN
            if (j >= 2 && (j - 2) % eff == 0 && (j - 2) / eff < nev) begin
                if (e[4]) exp_pos_x += (dx >= 0) ? 1 : -1;
                if (e[3]) exp_pos_y += (dy >= 0) ? 1 : -1;
            end
            if (j == clear_j + 1) begin
                exp_pos_x = 0;
                exp_pos_y = 0;
            end
            check($sformatf("%s_posx_j%0d", name, j), 32'(pos_x), 32'(exp_pos_x));
            check($sformatf("%s_posy_j%0d", name, j), 32'(pos_y), 32'(exp_pos_y));
            pos_clear = (j == clear_j);
`endif
            check($sformatf("%s_out_j%0d", name, j),
                  32'({step_x, step_y, done, busy, cmd_ready}), 32'(e));
            if (j == 1)
                check({name, "_dir"}, 32'({dir_x, dir_y}), 32'({dx >= 0, dy >= 0}));
            abort = (j == ja);
            @(posedge clock); #1;
        end
        abort = 1'b0;
`ifdef LINE_STEP_POS_TRACK_EN
        pos_clear = 1'b0;
`endif
        clear_j = NO_ABORT;
    endtask

    initial begin
        int dx, dy, per, ja;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_out", 32'({step_x, step_y, done, busy, cmd_ready}), 32'b00001);
        check("reset_dir", 32'({dir_x, dir_y}), 32'b00);
        reset = 1'b1;
        @(posedge clock); #1;

        run_move("diag",   5,  -3, 20, NO_ABORT);
        run_move("equal", -4,  -4, 10, NO_ABORT);
        run_move("zero",   0,   0, 12, NO_ABORT);
        run_move("clamp",  3,   2,  1, NO_ABORT);
        run_move("ymaj",  -2,   7,  9, NO_ABORT);
        run_move("abort", 100,  0, 10, 2 + 2 * 10 + 1);
        run_move("ab_acc", 5,   1, 10, -1);
        run_move("ab_gap", 6,  -6,  9, 2 + 9 + 6);
        run_move("minneg", -32768, 1, 8, 2 + 8 + 1);

`ifdef LINE_STEP_POS_TRACK_EN
        run_move("pos_a",  7, 0, 8, NO_ABORT);
        run_move("pos_b", -2, 0, 8, NO_ABORT);
        check("pos_sum", 32'(pos_x), 32'd5);
        clear_j = 2 + 8 - 1;
        run_move("pos_clr", 3, 0, 8, NO_ABORT);
`endif

        for (int r = 0; r < 10; r++) begin
            dx  = int'($urandom_range(0, 24)) - 12;
            dy  = int'($urandom_range(0, 24)) - 12;
            per = int'($urandom_range(1, 20));
            ja  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : NO_ABORT;
            run_move($sformatf("rnd%0d", r), dx, dy, per, ja);
        end

        // reset in the middle of a move
        cmd_valid  = 1'b1;
        cmd_dx     = 16'sd10;
        cmd_dy     = 16'sd0;
        cmd_period = 32'd10;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("mid_pre_step", 32'(step_x), 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check($sformatf("mid_rst_%0d", k), 32'({step_x, step_y, done, busy, cmd_ready}), 32'b00001);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check($sformatf("mid_post_%0d", k), 32'({step_x, step_y, done, busy, cmd_ready}), 32'b00001);
        end
        check("mid_dir", 32'({dir_x, dir_y}), 32'b00);
`ifdef LINE_STEP_POS_TRACK_EN
        exp_pos_x = 0;
        exp_pos_y = 0;
        check("mid_pos", 32'(pos_x), 32'd0);
`endif
        run_move("after_rst", 2, 1, 8, NO_ABORT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
